// File: rtl/ethernet_ones_complement_checksum.sv
// ethernet_ones_complement_checksum
// Passive RFC 1071 one's-complement checksum tap on an AXI-Stream RX bus.
// Bytes before START_BYTE are skipped; 16-bit big-endian words are summed
// from there to tlast, then folded and complemented one cycle later.
// Optional build macro: ETH_CSUM_TKEEP_MASK_EN (zero lanes with tkeep=0).
module ethernet_ones_complement_checksum #(
  parameter int DATA_W     = 64,
  parameter int START_BYTE = 34,
  parameter int ACC_W      = 24
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_W-1:0]     i_rx_axis_tdata,
  input  logic [DATA_W/8-1:0]   i_rx_axis_tkeep,
  input  logic                  i_rx_axis_tvalid,
  input  logic                  i_rx_axis_tlast,
  input  logic [15:0]           i_seed,
  output logic [15:0]           o_csum,
  output logic                  o_csum_ready,
  output logic                  o_csum_ok,
  output logic                  o_short,
  output logic                  o_busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int WORDS = DATA_W / 16;
  localparam int OFF_W = 16;

  typedef enum logic [1:0] {IDLE, SKIP, SUM, FOLD} state_t;

  state_t            state_reg, state_next;
  logic [OFF_W-1:0]  off_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [ACC_W-1:0]  fold_acc_reg;
  logic              short_pend_reg;
  logic [15:0]       csum_reg;
  logic              csum_ready_reg;
  logic              csum_ok_reg;
  logic              short_reg;

  logic [BYTES-1:0]  keep_gate;
  logic [BYTES-1:0]  lane_en;
  logic [DATA_W-1:0] masked;
  logic [ACC_W-1:0]  word_sum;
  logic [ACC_W-1:0]  acc_base;
  logic [ACC_W-1:0]  acc_next;
  logic [OFF_W:0]    beat_end;
  logic              beat_short;
  logic              first_beat;
  logic [ACC_W-1:0]  fold1;
  logic [16:0]       fold2;
  logic [15:0]       fold_sum;

`ifdef ETH_CSUM_TKEEP_MASK_EN
  assign keep_gate = i_rx_axis_tkeep;
`else
  // Legacy mode trusts upstream zero padding; tkeep is deliberately ignored.
  logic unused_tkeep;
  assign unused_tkeep = ^i_rx_axis_tkeep;
  assign keep_gate    = '1;
`endif

  // Offset 0 only ever occurs on the first beat, because the counter
  // always steps past 0 and then saturates once beyond START_BYTE.
  assign first_beat = (off_reg == '0);
  assign beat_end   = {1'b0, off_reg} + (OFF_W+1)'(BYTES);
  assign beat_short = (beat_end <= (OFF_W+1)'(START_BYTE));

  // Per-lane gate: lane must sit at or past START_BYTE and pass tkeep.
  generate
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [OFF_W-1:0] lane_off;
      assign lane_off    = off_reg + OFF_W'(gi);
      assign lane_en[gi] = (lane_off >= OFF_W'(START_BYTE)) && keep_gate[gi];
      assign masked[gi*8 +: 8] = lane_en[gi] ? i_rx_axis_tdata[gi*8 +: 8] : 8'h00;
    end
  endgenerate

  // Sum big-endian words of the beat and fold the previous carry back in.
  always_comb begin
    word_sum = '0;
    for (int k = 0; k < WORDS; k++) begin
      word_sum = word_sum + ACC_W'({masked[16*k +: 8], masked[16*k+8 +: 8]});
    end
    acc_base = first_beat ? ACC_W'(i_seed) : acc_reg;
    acc_next = ACC_W'(acc_base[15:0]) + ACC_W'(acc_base[ACC_W-1:16]) + word_sum;
  end

  // End-around carry of the captured frame sum.
  always_comb begin
    fold1    = ACC_W'(fold_acc_reg[15:0]) + ACC_W'(fold_acc_reg[ACC_W-1:16]);
    fold2    = {1'b0, fold1[15:0]} + 17'(fold1[ACC_W-1:16]);
    fold_sum = fold2[15:0] + 16'(fold2[16]);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next state: tlast always goes to FOLD, otherwise position picks SKIP/SUM.
  always_comb begin
    state_next = state_reg;
    if (i_rx_axis_tvalid) begin
      if (i_rx_axis_tlast)  state_next = FOLD;
      else if (beat_short)  state_next = SKIP;
      else                  state_next = SUM;
    end else if (state_reg == FOLD) begin
      state_next = IDLE;
    end
  end

  // Offset counter, accumulator, fold capture and registered results.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      off_reg        <= '0;
      acc_reg        <= '0;
      fold_acc_reg   <= '0;
      short_pend_reg <= 1'b0;
      csum_reg       <= '0;
      csum_ready_reg <= 1'b0;
      csum_ok_reg    <= 1'b0;
      short_reg      <= 1'b0;
    end else begin
      if (i_rx_axis_tvalid) begin
        if (i_rx_axis_tlast) begin
          off_reg        <= '0;
          fold_acc_reg   <= acc_next;
          acc_reg        <= '0;
          short_pend_reg <= beat_short;
        end else begin
          if (off_reg <= OFF_W'(START_BYTE)) off_reg <= beat_end[OFF_W-1:0];
          acc_reg <= acc_next;
        end
      end
      csum_ready_reg <= (state_reg == FOLD);
      if (state_reg == FOLD) begin
        csum_reg    <= ~fold_sum;
        csum_ok_reg <= (fold_sum == 16'hFFFF) && !short_pend_reg;
        short_reg   <= short_pend_reg;
      end
    end
  end

  assign o_csum       = csum_reg;
  assign o_csum_ready = csum_ready_reg;
  assign o_csum_ok    = csum_ok_reg;
  assign o_short      = short_reg;
  assign o_busy       = (state_reg != IDLE) || csum_ready_reg;

endmodule

// File: tb/tb_ethernet_ones_complement_checksum.sv
// Scoreboard bench: two instances (START_BYTE=0 and default 34) share the
// data bus with separate tvalid; expected results are queued at stimulus
// time and popped by per-instance monitors on each ready pulse.
module tb_ethernet_ones_complement_checksum;

  typedef struct {
    logic [15:0] csum;
    logic        ok;
    logic        sh;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] tdata = '0;
  logic [7:0]  tkeep = '0;
  logic        tlast = 1'b0;
  logic        valid0 = 1'b0;
  logic        valid34 = 1'b0;
  logic [15:0] seed = '0;

  logic [15:0] csum0, csum34;
  logic        rdy0, rdy34, ok0, ok34, sh0, sh34, busy0, busy34;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q34[$];
  exp_t e0, e34;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ethernet_ones_complement_checksum #(.DATA_W(64), .START_BYTE(0), .ACC_W(24)) dut0 (
    .i_clk(clk), .i_reset(reset), .i_rx_axis_tdata(tdata), .i_rx_axis_tkeep(tkeep),
    .i_rx_axis_tvalid(valid0), .i_rx_axis_tlast(tlast), .i_seed(seed),
    .o_csum(csum0), .o_csum_ready(rdy0), .o_csum_ok(ok0), .o_short(sh0), .o_busy(busy0)
  );

  ethernet_ones_complement_checksum dut34 (
    .i_clk(clk), .i_reset(reset), .i_rx_axis_tdata(tdata), .i_rx_axis_tkeep(tkeep),
    .i_rx_axis_tvalid(valid34), .i_rx_axis_tlast(tlast), .i_seed(seed),
    .o_csum(csum34), .o_csum_ready(rdy34), .o_csum_ok(ok34), .o_short(sh34), .o_busy(busy34)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // One beat, called at posedge+1; returns at the following posedge+1.
  task automatic beat(input bit sel, input logic [63:0] d, input logic [7:0] k,
                      input bit l, input logic [15:0] s,
                      input logic [15:0] ecsum, input bit eok, input bit esh);
    exp_t e;
    tdata = d; tkeep = k; tlast = l; seed = s;
    if (sel) valid34 = 1'b1; else valid0 = 1'b1;
    if (l) begin
      e.csum = ecsum; e.ok = eok; e.sh = esh; e.cyc = cyc + 2;
      if (sel) q34.push_back(e); else q0.push_back(e);
    end
    @(posedge clk); #1;
    valid0 = 1'b0; valid34 = 1'b0; tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Test-4 frame: bytes 0..33 = FF, byte 34 = 01, byte 35 = 02, rest 00.
  function automatic logic [63:0] pat(input int bt);
    logic [63:0] d;
    int off;
    d = '0;
    for (int b = 0; b < 8; b++) begin
      off = bt * 8 + b;
      d[b*8 +: 8] = (off < 34) ? 8'hFF : (off == 34) ? 8'h01 : (off == 35) ? 8'h02 : 8'h00;
    end
    return d;
  endfunction

  // Monitor for the START_BYTE=0 instance.
  always @(negedge clk) begin
    if (rdy0) begin
      if (q0.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut0_pulse: got unexpected pulse csum=%h, required no pulse", csum0);
      end else begin
        e0 = q0.pop_front();
        check("dut0_csum", 32'(csum0), 32'(e0.csum));
        check("dut0_ok", 32'(ok0), 32'(e0.ok));
        check("dut0_short", 32'(sh0), 32'(e0.sh));
        check("dut0_latency", cyc, e0.cyc);
      end
    end
  end

  // Monitor for the START_BYTE=34 instance.
  always @(negedge clk) begin
    if (rdy34) begin
      if (q34.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL dut34_pulse: got unexpected pulse csum=%h, required no pulse", csum34);
      end else begin
        e34 = q34.pop_front();
        check("dut34_csum", 32'(csum34), 32'(e34.csum));
        check("dut34_ok", 32'(ok34), 32'(e34.ok));
        check("dut34_short", 32'(sh34), 32'(e34.sh));
        check("dut34_latency", cyc, e34.cyc);
      end
    end
  end

  initial begin
    logic [15:0] t3_csum;
`ifdef ETH_CSUM_TKEEP_MASK_EN
    t3_csum = 16'hEDCB;
`else
    t3_csum = 16'h42CB;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_csum", 32'(csum0), 32'h0);
    check("reset_ready", 32'(rdy0), 32'h0);
    check("reset_ok", 32'(ok0), 32'h0);
    check("reset_short", 32'(sh0), 32'h0);
    check("reset_busy", 32'({busy0, busy34}), 32'h0);

    // 1: single beat 0x1234
    beat(0, 64'h3412, 8'hFF, 1, 16'h0000, 16'hEDCB, 0, 0);
    idle(3);
    // 2: two beats of all FF
    beat(0, '1, 8'hFF, 0, 16'h0000, 16'h0, 0, 0);
    beat(0, '1, 8'hFF, 1, 16'h0000, 16'h0000, 1, 0);
    idle(3);
    // 3: partial beat with tkeep=03
    beat(0, 64'h00AB_3412, 8'h03, 1, 16'h0000, t3_csum, 0, 0);
    idle(3);

    // 4: default offset, 6 beats
    for (int i = 0; i < 6; i++) begin
      beat(1, pat(i), 8'hFF, i == 5, 16'h0000, 16'hFEFD, 0, 0);
      if (i == 0) check("busy_mid_frame", 32'(busy34), 32'h1);
    end
    idle(3);
    // 4b: tlast at beat 3 (bytes 24..31) -> short
    for (int i = 0; i < 4; i++) beat(1, pat(i), 8'hFF, i == 3, 16'h0000, 16'hFFFF, 0, 1);
    idle(3);
    // 4c: tlast at beat 4 (bytes 32..39) just reaches the start -> not short
    for (int i = 0; i < 5; i++) beat(1, pat(i), 8'hFF, i == 4, 16'h0000, 16'hFEFD, 0, 0);
    idle(3);
    // 4d: single short beat returns ~seed
    beat(1, pat(0), 8'hFF, 1, 16'h1234, 16'hEDCB, 0, 1);
    idle(3);

    // 5: back-to-back, B starts right after A's tlast, with a tvalid gap in B
    beat(0, 64'h3412, 8'hFF, 1, 16'h0000, 16'hEDCB, 0, 0);
    beat(0, 64'hFEFF, 8'hFF, 0, 16'h0001, 16'h0, 0, 0);
    idle(2);
    beat(0, 64'h0, 8'hFF, 1, 16'h0000, 16'h0000, 1, 0);
    idle(3);

    // 6: reset in the middle of a frame, then a clean test-1 frame
    beat(0, 64'hFFFF_FFFF, 8'hFF, 0, 16'h5555, 16'h0, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    beat(0, 64'h3412, 8'hFF, 1, 16'h0000, 16'hEDCB, 0, 0);

    for (int i = 0; i < 50 && (q0.size() != 0 || q34.size() != 0); i++) @(posedge clk);
    idle(4);
    check("pending_dut0", 32'(q0.size()), 32'h0);
    check("pending_dut34", 32'(q34.size()), 32'h0);
    check("idle_busy", 32'({busy0, busy34}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_ones_complement_checksum.md
Name: ethernet_ones_complement_checksum

Overview:
Parametrised streaming RFC 1071 one's-complement checksum engine for the Ethernet RX path. It taps an AXI-Stream frame bus passively and skips a fixed header prefix. From there it sums 16-bit big-endian words to tlast, honouring tkeep and tvalid stalls. Each frame produces a checksum value, a ready pulse and a verify flag. It generalises the fixed ICMP counter to any DATA_W, any start offset, partial beats, seeding and back-to-back frames.

Parameters:
DATA_W, 64, stream data width in bits; multiple of 16, range 16..512.
START_BYTE, 34, frame byte offset where summing begins; must be even.
ACC_W, 24, accumulator width; must be at least 17 + clog2(DATA_W/16).

Ports:
i_clk  in  1  clock.
i_reset  in  1  synchronous, active-high reset.
i_rx_axis_tdata  in  DATA_W  frame data; lane 0 (bits 7:0) is first byte on wire.
i_rx_axis_tkeep  in  DATA_W/8  byte-valid mask.
i_rx_axis_tvalid  in  1  beat valid; bus is monitored only, there is no tready.
i_rx_axis_tlast  in  1  last beat of frame.
i_seed  in  16  initial sum (e.g. folded pseudo-header); sampled on the first accepted beat of each frame.
o_csum  out  16  final checksum, ~fold(sum); held until the next result.
o_csum_ready  out  1  one-cycle pulse when o_csum/o_csum_ok are valid.
o_csum_ok  out  1  1 when fold(sum) == 16'hFFFF (received checksum verifies).
o_short  out  1  with o_csum_ready: frame ended at or before START_BYTE.
o_busy  out  1  high from the first accepted beat through the ready pulse.

Behaviour:
- Beat accepted when i_rx_axis_tvalid=1. No state change on tvalid=0.
- Byte counter tracks frame offset: 0 on the first beat after reset or after a tlast beat; +DATA_W/8 per beat.
- Byte lane b at offset off+b is summed only if off+b >= START_BYTE and the tkeep gate passes (see Optional Feature). Otherwise the lane is treated as 0x00.
- Word k of a beat = {lane 2k, lane 2k+1}.
- States: IDLE (no beat yet), SKIP (all lanes below START_BYTE), SUM, FOLD.
- IDLE -> SKIP or SUM on the first beat, chosen by offset. SKIP -> SUM when the beat reaches START_BYTE. Any state -> FOLD on a tlast beat.
- Accumulate per beat: acc <= {0, acc[15:0]} + acc[ACC_W-1:16] + sum of masked words. The first beat of a frame uses i_seed in place of acc.
- Tlast beat: final acc is copied into a separate fold register and acc is cleared. A new frame may start in the very next cycle.
- Fold stage (1 cycle): s = lo16 + hi, then s = s[15:0] + s[16].
  - o_csum <= ~s, o_csum_ok <= (s == 16'hFFFF).
  - o_csum_ready pulses.
- Latency: o_csum_ready is high exactly 2 cycles after the tlast beat's clock edge.
- o_short = 1 if the frame's tlast beat covers no byte >= START_BYTE. In that case o_csum = ~i_seed folded and o_csum_ok = 0.
- A tlast on the first beat is legal and gives a single-beat result.
- Reset values: o_csum=0, o_csum_ready=0, o_csum_ok=0, o_short=0, o_busy=0, state IDLE, counters and acc 0.
- Reset mid-frame: frame discarded, no ready pulse. The next beat is offset 0.

Optional Feature:
ETH_CSUM_TKEEP_MASK_EN
- Defined: lanes with tkeep=0 are treated as 0x00.
- Undefined: tkeep is ignored and all lanes are summed (legacy behaviour; requires upstream zero-padding). The port remains present but unused.

Test Plan:
1. START_BYTE=0, one beat: lane0=0x12, lane1=0x34, others 0, tkeep=FF, tlast, seed 0 -> 2 cycles later: ready pulse, o_csum=0xEDCB, o_csum_ok=0, o_short=0.
2. START_BYTE=0, two beats of all 0xFF, tkeep=FF (sum 0x7FFF8 -> fold 0xFFFF) -> o_csum=0x0000, o_csum_ok=1.
3. START_BYTE=0, lanes 0..2 = 12,34,AB, tkeep=0x03:
   - macro defined -> o_csum=0xEDCB.
   - macro undefined -> o_csum=0x42CB.
4. Defaults (34), 6 beats: bytes 0..33=0xFF, byte34=0x01, byte35=0x02, rest 0 -> o_csum=0xFEFD. Repeat with a tlast at beat 3 -> o_short=1.
5. Back-to-back frames with tvalid gaps:
   - frame A = test 1, frame B starts the cycle after A's tlast.
   - frame B seed=0x0001, word 0xFFFE -> A gives 0xEDCB, then B gives 0x0000 with ok=1; one pulse each.
6. Assert i_reset mid-frame, then send frame of test 1 -> no pulse for the aborted frame, correct 0xEDCB for the new one.
